// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: hex-to-segment table,
// segment bit positions and the display record held in the display/pending registers.
package seg_pkg;

  // Widest display the record can carry; instances must use NUM_DIGITS <= MAX_DIGITS.
  localparam int MAX_DIGITS = 8;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]   dp;
    logic [MAX_DIGITS-1:0]   blank;
  } disp_rec_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to active-high a..g segment lookup.
// Zero latency, no flow control.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver; outputs registered, updated on each slot tick.
// Load is valid/ready, one-entry pending buffer committed at frame start; optional SEG_LZ_SUPPRESS_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic [NUM_DIGITS-1:0]   in_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int SEL_W = $clog2(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  disp_rec_t             display;
  disp_rec_t             display_nxt;
  disp_rec_t             pending;
  disp_rec_t             in_rec;
  logic                  pending_flag;
  logic                  tick;
  logic                  wrap;
  logic                  xfer;
  logic [SEL_W-1:0]      sel;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [MAX_DIGITS-1:0] dark;
  logic                  sel_dark;
  logic [NUM_DIGITS-1:0] an_nxt;
`ifdef SEG_LZ_SUPPRESS_EN
  logic [3:0]            upper_or;
`endif

  assign in_ready = !pending_flag;
  assign xfer     = in_valid && in_ready;
  assign tick     = (cnt == CNT_LAST);
  assign wrap     = tick && (idx == IDX_LAST);

  always_comb begin
    in_rec = '0;
    in_rec.value[4*NUM_DIGITS-1:0] = in_value;
    in_rec.dp[NUM_DIGITS-1:0]      = in_dp;
    in_rec.blank[NUM_DIGITS-1:0]   = in_blank;
  end

  always_comb begin
    idx_nxt = idx;
    if (wrap) begin
      idx_nxt = '0;
    end else if (tick) begin
      idx_nxt = idx + IDX_W'(1);
    end
  end

  // A transfer landing on the frame-start tick bypasses pending so digit 0 already shows it.
  always_comb begin
    display_nxt = display;
    if (wrap) begin
      if (xfer) begin
        display_nxt = in_rec;
      end else if (pending_flag) begin
        display_nxt = pending;
      end
    end
  end

  always_comb begin
    dark = display_nxt.blank;
`ifdef SEG_LZ_SUPPRESS_EN
    upper_or = '0;
    for (int k = MAX_DIGITS - 1; k > 0; k--) begin
      upper_or = upper_or | display_nxt.value[4*k +: 4];
      if ((upper_or == 4'd0) && !display_nxt.dp[k]) begin
        dark[k] = 1'b1;
      end
    end
`endif
  end

  assign sel      = SEL_W'(idx_nxt);
  assign nibble   = display_nxt.value[{sel, 2'b00} +: 4];
  assign sel_dark = dark[sel];

  seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    an_nxt = '0;
    if (!sel_dark) begin
      an_nxt[idx_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= IDX_LAST;
      display      <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
      seg          <= '0;
      dp           <= 1'b0;
      an           <= '0;
      frame_start  <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + CNT_W'(1);
      idx         <= idx_nxt;
      display     <= display_nxt;
      frame_start <= wrap;
      if (xfer && !wrap) begin
        pending      <= in_rec;
        pending_flag <= 1'b1;
      end else if (wrap) begin
        pending_flag <= 1'b0;
      end
      if (tick) begin
        seg <= sel_dark ? 7'h00 : dec_seg;
        dp  <= !sel_dark && display_nxt.dp[sel];
        an  <= an_nxt;
      end
    end
  end

endmodule
